// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshakes and serializer link of the two-port UART transmit arbiter
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [7:0] req0_data;
  logic [7:0] req1_data;
  logic       req0_lock;
  logic       req1_lock;
  logic       req0_ready;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [1:0] grant;
  logic       idle;
  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, req0_lock, req1_lock, tx_busy,
    input  req0_ready, req1_ready, tx_start, tx_data, grant, idle
  );
  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, req0_lock, req1_lock, tx_busy,
    output req0_ready, req1_ready, tx_start, tx_data, grant, idle
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: arbitrates two byte requesters onto one UART serializer; define UART_ARB_LOCK_EN for multi-byte message locking
module uart_tx_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int LOCK_MAX   = 16
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;
  logic last_grant, lock_on, v0, v1, pick1, can_accept, hs;
  assign can_accept     = state == IDLE && !bus.tx_busy && !reset;
  assign v0             = bus.req0_valid && !(lock_on && last_grant);
  assign v1             = bus.req1_valid && !(lock_on && !last_grant);
  assign pick1          = v1 && (!v0 || (!FIXED_PRIO && !last_grant));
  assign bus.req0_ready = can_accept && v0 && !pick1;
  assign bus.req1_ready = can_accept && pick1;
  assign bus.idle       = state == IDLE;
  assign hs             = bus.req0_ready | bus.req1_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= IDLE;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.grant    <= 2'b00;
      last_grant   <= 1'b1;
    end else
      case (state)
        IDLE:
          if (hs) begin
            state        <= ISSUE;
            bus.tx_start <= 1'b1;
            bus.tx_data  <= pick1 ? bus.req1_data : bus.req0_data;
            bus.grant    <= pick1 ? 2'b10 : 2'b01;
          end
        ISSUE: begin
          state        <= WAIT_BUSY;
          bus.tx_start <= 1'b0;
        end
        WAIT_BUSY:
          if (bus.tx_busy) state <= WAIT_DONE;
        WAIT_DONE:
          if (!bus.tx_busy) begin
            state      <= IDLE;
            last_grant <= bus.grant[1];
            bus.grant  <= 2'b00;
          end
        default: state <= IDLE;
      endcase
`ifdef UART_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic          locked, hs_lock;
  logic [CW-1:0] burst;
  assign hs_lock = pick1 ? bus.req1_lock : bus.req0_lock;
  // the owner keeps the port while it still offers a byte or holds lock, up to LOCK_MAX bytes
  assign lock_on = locked && burst < CW'(LOCK_MAX) &&
                   (last_grant ? (bus.req1_valid | bus.req1_lock) : (bus.req0_valid | bus.req0_lock));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      locked <= 1'b0;
      burst  <= '0;
    end else if (hs) begin
      locked <= hs_lock;
      burst  <= !hs_lock ? '0 : lock_on ? burst + 1'b1 : CW'(1);
    end
`else
  localparam int unused_lock_max = LOCK_MAX;
  logic unused_lock;
  assign lock_on     = 1'b0;
  assign unused_lock = bus.req0_lock ^ bus.req1_lock;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench driving a round-robin and a fixed-priority arbiter side by side
module tb_uart_tx_arbiter;
  localparam int BUSY = 870;
  localparam int GAP  = BUSY + 3;
  typedef struct {
    logic       v0, v1, busy;
    logic [1:0] ra, rb;
  } vec_t;
  logic       clk = 0, reset = 0;
  logic       v0 = 0, v1 = 0, l0 = 0, l1 = 0, force_busy = 0;
  logic [7:0] d0 = 0, d1 = 0;
  logic [7:0] held_a = 0, held_b = 0;
  logic       busy_a = 0, busy_b = 0;
  int         left_a = 0, left_b = 0;
  int         n_chk = 0, n_fail = 0, cyc = 0, hs_a = -10, prev_a = -1, n_start_a = 0;
  bit         chk_gap = 0;
  logic [9:0] qa[$], qb[$];
  uart_tx_arbiter_if ia();
  uart_tx_arbiter_if ib();
  uart_tx_arbiter #(.FIXED_PRIO(1'b0), .LOCK_MAX(4)) dut    (.clk(clk), .reset(reset), .bus(ia.slave));
  uart_tx_arbiter #(.FIXED_PRIO(1'b1), .LOCK_MAX(4)) dut_fp (.clk(clk), .reset(reset), .bus(ib.slave));
  always #5 clk = ~clk;
  assign ia.req0_valid = v0;
  assign ia.req1_valid = v1;
  assign ia.req0_data  = d0;
  assign ia.req1_data  = d1;
  assign ia.req0_lock  = l0;
  assign ia.req1_lock  = l1;
  assign ia.tx_busy    = busy_a | force_busy;
  assign ib.req0_valid = v0;
  assign ib.req1_valid = v1;
  assign ib.req0_data  = d0;
  assign ib.req1_data  = d1;
  assign ib.req0_lock  = l0;
  assign ib.req1_lock  = l1;
  assign ib.tx_busy    = busy_b | force_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // serializer models: busy rises the cycle after tx_start and stays high BUSY cycles
  always @(posedge clk or posedge reset)
    if (reset) begin
      busy_a <= 0; left_a <= 0; busy_b <= 0; left_b <= 0;
    end else begin
      if (ia.tx_start) begin busy_a <= 1; left_a <= BUSY - 1; end
      else if (busy_a) begin if (left_a == 0) busy_a <= 0; else left_a <= left_a - 1; end
      if (ib.tx_start) begin busy_b <= 1; left_b <= BUSY - 1; end
      else if (busy_b) begin if (left_b == 0) busy_b <= 0; else left_b <= left_b - 1; end
    end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((ia.req0_valid && ia.req0_ready) || (ia.req1_valid && ia.req1_ready)) hs_a <= cyc;
  end

  always @(negedge clk)
    if (reset) prev_a <= -1;
    else begin
      chk("exclusive", 32'({ia.req0_ready & ia.req1_ready, &ia.grant, ib.req0_ready & ib.req1_ready, &ib.grant}), 0);
      if (ia.tx_start) begin
        n_start_a <= n_start_a + 1;
        chk("latency_a", cyc - hs_a, 1);
        if (chk_gap && prev_a >= 0) chk("gap_a", cyc - prev_a, GAP);
        prev_a <= cyc;
        held_a <= ia.tx_data;
        chk("start_a_expected", 32'(qa.size() != 0), 1);
        if (qa.size() != 0) chk("byte_a", 32'({ia.grant, ia.tx_data}), 32'(qa.pop_front()));
      end else if (ia.grant != 0) chk("hold_a", 32'(ia.tx_data), 32'(held_a));
      if (ib.tx_start) begin
        held_b <= ib.tx_data;
        chk("start_b_expected", 32'(qb.size() != 0), 1);
        if (qb.size() != 0) chk("byte_b", 32'({ib.grant, ib.tx_data}), 32'(qb.pop_front()));
      end else if (ib.grant != 0) chk("hold_b", 32'(ib.tx_data), 32'(held_b));
    end

  task automatic wait_q();
    int k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 6000) begin
      @(negedge clk); #2; k++;
    end
    chk("queue_drained", qa.size() + qb.size(), 0);
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (!ia.idle && k < 3000) begin
      @(negedge clk); #2; k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; v0 = 0; v1 = 0; l0 = 0; l1 = 0; force_busy = 0; chk_gap = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    vec_t tbl[7];
    int   k, base;
    tbl[0] = '{0, 0, 0, 2'b00, 2'b00};
    tbl[1] = '{1, 0, 0, 2'b01, 2'b01};
    tbl[2] = '{0, 1, 0, 2'b10, 2'b10};
    tbl[3] = '{1, 1, 0, 2'b01, 2'b01};
    tbl[4] = '{1, 1, 1, 2'b00, 2'b00};
    tbl[5] = '{0, 1, 1, 2'b00, 2'b00};
    tbl[6] = '{1, 0, 1, 2'b00, 2'b00};
    #1 reset = 1; v0 = 1; v1 = 1; d0 = 8'hFF; d1 = 8'hEE;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'({ia.req1_ready, ia.req0_ready}), 0);
    chk("rst_grant", 32'(ia.grant), 0);
    chk("rst_start", 32'(ia.tx_start), 0);
    chk("rst_data", 32'(ia.tx_data), 0);
    v0 = 0; v1 = 0;
    @(negedge clk); reset = 0; #1;
    chk("idle_after_reset", 32'(ia.idle), 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      v0 = tbl[i].v0; v1 = tbl[i].v1; force_busy = tbl[i].busy; #1;
      chk("tbl_ready_rr", 32'({ia.req1_ready, ia.req0_ready}), 32'(tbl[i].ra));
      chk("tbl_ready_fp", 32'({ib.req1_ready, ib.req0_ready}), 32'(tbl[i].rb));
      chk("tbl_idle", 32'(ia.idle), 1);
      v0 = 0; v1 = 0; force_busy = 0;
    end
    // single byte from req0, then tie after req0 owned the port
    do_reset();
    d0 = 8'h3F; v0 = 1;
    qa.push_back({2'b01, 8'h3F}); qb.push_back({2'b01, 8'h3F});
    wait_q(); v0 = 0;
    wait_idle(k);
    chk("idle_return", k, BUSY + 2);
    chk("busy_low_at_idle", 32'(ia.tx_busy), 0);
    v0 = 1; v1 = 1; #1;
    chk("rr_tie_after_r0", 32'({ia.req1_ready, ia.req0_ready}), 2);
    chk("fp_tie_after_r0", 32'({ib.req1_ready, ib.req0_ready}), 1);
    v0 = 0; v1 = 0;
    // both valid from reset: alternate on round-robin, req0 only on fixed priority
    do_reset();
    d0 = 8'hA5; d1 = 8'h5A; v0 = 1; v1 = 1; chk_gap = 1;
    for (int i = 0; i < 4; i++) begin
      qa.push_back(i % 2 ? {2'b10, 8'h5A} : {2'b01, 8'hA5});
      qb.push_back({2'b01, 8'hA5});
    end
    wait_q(); v0 = 0; v1 = 0; chk_gap = 0;
    // req0 streams with lock high while req1 waits
    do_reset();
    d0 = 8'hC3; d1 = 8'h3C; l0 = 1; v0 = 1; v1 = 1; chk_gap = 1;
    for (int i = 0; i < 6; i++) begin
`ifdef UART_ARB_LOCK_EN
      qa.push_back(i == 4 ? {2'b10, 8'h3C} : {2'b01, 8'hC3});
`else
      qa.push_back(i % 2 ? {2'b10, 8'h3C} : {2'b01, 8'hC3});
`endif
      qb.push_back({2'b01, 8'hC3});
    end
    wait_q(); v0 = 0; v1 = 0; l0 = 0; chk_gap = 0;
    // locked owner drops valid but keeps lock
    do_reset();
    d0 = 8'hC3; d1 = 8'h3C; l0 = 1; v0 = 1;
    qa.push_back({2'b01, 8'hC3}); qb.push_back({2'b01, 8'hC3});
    wait_q(); v0 = 0; v1 = 1;
`ifdef UART_ARB_LOCK_EN
    base = n_start_a;
    repeat (1000) @(negedge clk);
    #2;
    chk("lock_hold_starts", n_start_a - base, 0);
    chk("lock_hold_ready", 32'(ia.req1_ready), 0);
    chk("lock_hold_idle", 32'(ia.idle), 1);
    l0 = 0;
`endif
    qa.push_back({2'b10, 8'h3C}); qb.push_back({2'b10, 8'h3C});
    wait_q(); v1 = 0; l0 = 0;
    // serializer still busy when reset releases
    @(negedge clk);
    reset = 1; force_busy = 1; v0 = 0; v1 = 1; d1 = 8'h77;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      #1 chk("busy_blocks_ready", 32'(ia.req1_ready), 0);
      @(negedge clk);
    end
    force_busy = 0; #1;
    chk("ready_when_busy_falls", 32'(ia.req1_ready), 1);
    qa.push_back({2'b10, 8'h77}); qb.push_back({2'b10, 8'h77});
    wait_q(); v1 = 0;
    // reset in the middle of a frame
    do_reset();
    d0 = 8'h3F; v0 = 1;
    qa.push_back({2'b01, 8'h3F}); qb.push_back({2'b01, 8'h3F});
    wait_q(); v0 = 0;
    repeat (100) @(negedge clk);
    #1 chk("grant_before_abort", 32'(ia.grant), 1);
    reset = 1; #1;
    chk("abort_grant", 32'(ia.grant), 0);
    chk("abort_start", 32'(ia.tx_start), 0);
    chk("abort_ready", 32'({ia.req1_ready, ia.req0_ready}), 0);
    @(negedge clk); reset = 0; #1;
    chk("idle_after_abort", 32'(ia.idle), 1);
    d0 = 8'hA5; d1 = 8'h5A; v0 = 1; v1 = 1;
    qa.push_back({2'b01, 8'hA5}); qb.push_back({2'b01, 8'hA5});
    wait_q(); v0 = 0; v1 = 0;
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
